// File: rtl/stopwatch_display_scan.sv
// ---------------------------------------------------------------------------
// stopwatch_display_scan
//
// Purpose:
//   Time-multiplexes the four live stopwatch digits (M.SS.m) or the four lap
//   snapshot digits onto one 4-digit common-anode 7-segment display. Also
//   owns the live/lap view selection, driven by the raw lap and view buttons.
//
//   Each digit owns a slot of REFRESH_DIV clocks. The first GUARD_CYCLES
//   clocks of every slot blank the display so the previous digit's segments
//   never ghost onto the next anode. A lap press shows the lap snapshot for
//   HOLD_SLOTS slots and then reverts to live. A view press pins the lap view
//   until the next view press.
//
// Ports:
//   clk                 in   1  system clock
//   rst                 in   1  asynchronous reset, active-low
//   minutes             in   4  live BCD minutes
//   seconds_msd         in   4  live BCD seconds tens
//   seconds_lsd         in   4  live BCD seconds units
//   ms_msd              in   4  live BCD tenths
//   lap_ct_minutes      in   4  lap BCD minutes
//   lap_ct_seconds_msd  in   4  lap BCD seconds tens
//   lap_ct_seconds_lsd  in   4  lap BCD seconds units
//   lap_ct_ms           in   4  lap BCD tenths
//   lap                 in   1  raw lap button, asynchronous to clk
//   view                in   1  raw view-toggle button, asynchronous to clk
//   an                  out  4  anodes, active-low, an[0] is the rightmost
//   seg                 out  7  segments {g,f,e,d,c,b,a}, active-low
//   dp                  out  1  decimal point, active-low
//   lap_active          out  1  high while lap digits are being displayed
// ---------------------------------------------------------------------------
module stopwatch_display_scan #(
    parameter int REFRESH_DIV  = 100000,
    parameter int GUARD_CYCLES = 16,
    parameter int HOLD_SLOTS   = 3000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] minutes,
    input  logic [3:0] seconds_msd,
    input  logic [3:0] seconds_lsd,
    input  logic [3:0] ms_msd,
    input  logic [3:0] lap_ct_minutes,
    input  logic [3:0] lap_ct_seconds_msd,
    input  logic [3:0] lap_ct_seconds_lsd,
    input  logic [3:0] lap_ct_ms,
    input  logic       lap,
    input  logic       view,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       lap_active
);

    localparam int DIV_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int HOLD_W = (HOLD_SLOTS > 0) ? $clog2(HOLD_SLOTS + 1) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(REFRESH_DIV - 1);
    localparam logic [DIV_W-1:0]  GUARD_END  = DIV_W'(GUARD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LOAD  = HOLD_W'(HOLD_SLOTS);

    // View-selection states
    localparam logic [1:0] ST_LIVE   = 2'd0;
    localparam logic [1:0] ST_SHOW   = 2'd1;
    localparam logic [1:0] ST_PINNED = 2'd2;

    // All segments off and the dash shown for non-BCD digit codes
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    logic              lap_s1, lap_s2, lap_s3;
    logic              view_s1, view_s2, view_s3;
    logic              lap_p, view_p;

    logic [DIV_W-1:0]  div;
    logic [1:0]        slot;
    logic              slot_end;
    logic              slot_start;
    logic              in_guard;

    logic [1:0]        state, state_next;
    logic [HOLD_W-1:0] hold, hold_next;

    logic              use_lap;
    logic [3:0]        digit_next;
    logic [3:0]        digit_q;
    logic [3:0]        digit_shown;
    logic [3:0]        anode_pattern;

    // -----------------------------------------------------------------------
    // Button synchronizers. Two flops bring each raw button into the clk
    // domain; the third flop holds the previous synchronized level so a
    // rising edge yields exactly one pulse, however long the button is held.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lap_s1  <= 1'b0;
            lap_s2  <= 1'b0;
            lap_s3  <= 1'b0;
            view_s1 <= 1'b0;
            view_s2 <= 1'b0;
            view_s3 <= 1'b0;
        end else begin
            lap_s1  <= lap;
            lap_s2  <= lap_s1;
            lap_s3  <= lap_s2;
            view_s1 <= view;
            view_s2 <= view_s1;
            view_s3 <= view_s2;
        end
    end

    assign lap_p  = lap_s2 & ~lap_s3;
    assign view_p = view_s2 & ~view_s3;

    // -----------------------------------------------------------------------
    // Slot timing: div walks through one slot, slot picks the digit/anode.
    // -----------------------------------------------------------------------
    assign slot_end   = (div == DIV_LAST);
    assign slot_start = (div == '0);
    assign in_guard   = (div < GUARD_END);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div  <= '0;
            slot <= 2'd0;
        end else if (slot_end) begin
            div  <= '0;
            slot <= slot + 2'd1;
        end else begin
            div  <= div + DIV_W'(1);
        end
    end

    // -----------------------------------------------------------------------
    // View selection. A view press always wins over a simultaneous lap press.
    // In SHOW, a fresh lap press restarts the hold count even on the cycle a
    // slot ends, so the reload takes priority over the decrement.
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state;
        hold_next  = hold;
        case (state)
            ST_LIVE: begin
                if (view_p) begin
                    state_next = ST_PINNED;
                end else if (lap_p) begin
                    state_next = ST_SHOW;
                    hold_next  = HOLD_LOAD;
                end
            end
            ST_SHOW: begin
                if (view_p) begin
                    state_next = ST_PINNED;
                end else if (lap_p) begin
                    hold_next  = HOLD_LOAD;
                end else if (hold == '0) begin
                    state_next = ST_LIVE;
                end else if (slot_end) begin
                    hold_next = hold - HOLD_W'(1);
                    if (hold == HOLD_W'(1)) begin
                        state_next = ST_LIVE;
                    end
                end
            end
            ST_PINNED: begin
                if (view_p) begin
                    state_next = ST_LIVE;
                end
            end
            default: begin
                state_next = ST_LIVE;
                hold_next  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_LIVE;
            hold  <= '0;
        end else begin
            state <= state_next;
            hold  <= hold_next;
        end
    end

    // -----------------------------------------------------------------------
    // Digit source for the current slot. Slot 0 is the rightmost digit
    // (tenths), slot 3 the leftmost (minutes).
    // -----------------------------------------------------------------------
    assign use_lap = (state != ST_LIVE);

    always_comb begin
        digit_next = 4'h0;
        case (slot)
            2'd0: digit_next = use_lap ? lap_ct_ms          : ms_msd;
            2'd1: digit_next = use_lap ? lap_ct_seconds_lsd : seconds_lsd;
            2'd2: digit_next = use_lap ? lap_ct_seconds_msd : seconds_msd;
            2'd3: digit_next = use_lap ? lap_ct_minutes     : minutes;
        endcase
    end

    // The digit (and the live/lap choice behind it) is captured once at the
    // start of each slot, so a source or value change mid-slot cannot alter
    // what the lit digit shows until the next slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            digit_q <= 4'h0;
        end else if (slot_start) begin
            digit_q <= digit_next;
        end
    end

    // On the very first cycle of a slot the capture register still holds the
    // previous slot's digit, so the value being captured is used directly.
    assign digit_shown = slot_start ? digit_next : digit_q;

    always_comb begin
        anode_pattern       = 4'b1111;
        anode_pattern[slot] = 1'b0;
    end

    function automatic logic [6:0] decode_digit(input logic [3:0] value);
        logic [6:0] pattern;
        case (value)
            4'd0:    pattern = 7'h40;
            4'd1:    pattern = 7'h79;
            4'd2:    pattern = 7'h24;
            4'd3:    pattern = 7'h30;
            4'd4:    pattern = 7'h19;
            4'd5:    pattern = 7'h12;
            4'd6:    pattern = 7'h02;
            4'd7:    pattern = 7'h78;
            4'd8:    pattern = 7'h00;
            4'd9:    pattern = 7'h10;
            default: pattern = SEG_DASH;
        endcase
        return pattern;
    endfunction

    // -----------------------------------------------------------------------
    // Registered display pins. The decimal points sit after the seconds-lsd
    // and minutes digits (slots 1 and 3), giving the M.SS.m readout.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an         <= 4'hF;
            seg        <= SEG_BLANK;
            dp         <= 1'b1;
            lap_active <= 1'b0;
        end else begin
            lap_active <= use_lap;
            if (in_guard) begin
                an  <= 4'hF;
                seg <= SEG_BLANK;
                dp  <= 1'b1;
            end else begin
                an  <= anode_pattern;
                seg <= decode_digit(digit_shown);
                dp  <= ~slot[0];
            end
        end
    end

endmodule
